service_packet_encoder: RTL and testbench
=========================================

# service_packet_encoder

Transmit-side framer for the service protocol carried over the SPI link. On a start command it emits one complete reply packet as a stream of 16-bit words: address word, size/command word, payload words pulled from a FIFO, 16-bit checksum, trailer. It sits between the reply buffers (status or received MIL data) and the SPI slave output path, and is the encoder counterpart of the packet decoder that feeds inPacketStart/inCmdCode/inWordNum.

## Interface
- ADDR_W, 8, address field width (fixed at 8 by the protocol)
- MAX_SIZE, 255, largest payload word count accepted
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches addr, cmd, size; ignored while busy
- addr  in  8  packet address
- cmd  in  8  command code (ServiceProtocol code, e.g. 8'hB0 status reply, 8'hB2 data reply)
- size  in  8  payload word count, 0..MAX_SIZE
- pop_request  out  1  asks the payload source for the next word
- pop_done  in  1  one-cycle pulse; pop_data valid this cycle
- pop_data  in  16  payload word
- push_request  out  1  offers push_data to the SPI output path
- push_done  in  1  one-cycle pulse; sink has taken push_data
- push_data  out  16  current outgoing word
- busy  out  1  high from the cycle after start until packet end
- word_num  out  8  index of the payload word currently being pushed
- packet_end  out  1  one-cycle pulse after the trailer is accepted

## Operation
- Packet word order: {addr, 8'h00}; {size, cmd}; size payload words; checksum; 16'h0000 trailer.
- Checksum = modulo-2^16 sum of the header words and all payload words; carries discarded; trailer excluded.
- FSM states: IDLE, ADDR, SIZE, FETCH, DATA, CSUM, TAIL.
- IDLE: on start, latch fields, clear checksum and word counter, go to ADDR.
- ADDR/SIZE/DATA/CSUM/TAIL: hold push_request high with the word stable; on push_done add the word to the checksum (except CSUM/TAIL) and advance.
- After SIZE: go to FETCH if size != 0, else CSUM.
- FETCH: pop_request high until pop_done; capture pop_data, go to DATA.
- DATA: on push_done increment word_num; go to FETCH if more words remain, else CSUM.
- TAIL: on push_done pulse packet_end, return to IDLE.
- size > MAX_SIZE: the packet is framed with size clamped to MAX_SIZE, in both the header and the word count.
- push_done or pop_done outside the matching request is ignored.

## Timing
- Reset values: state IDLE, busy 0, push_request 0, pop_request 0, push_data 0, word_num 0, packet_end 0, checksum 0.
- Reset is asynchronous. rst mid-packet aborts immediately and emits no further words.
- Start to first push_request: 1 cycle.
- push_request drops in the cycle after push_done. The next word's request rises one cycle later, or after the FETCH completes.
- pop_request drops in the cycle after pop_done.
- Minimum packet duration with zero-wait sinks: 2 cycles per header, checksum and trailer word, plus 4 cycles per payload word.
- start coincident with the TAIL push_done is ignored. start is accepted from IDLE only.
- busy falls in the same cycle packet_end is high.

## Structure
- Command codes and header layout (address byte position, size/cmd packing, trailer value 16'h0000) go in the ServiceProtocol package next to the existing TCC_* codes.
- Add a checksum function: 16-bit add without carry.
- FSM state enum is local to the module.
- One natural sub-module: service_checksum_acc, a clearable 16-bit accumulator with add-enable.

## Test plan
- Status reply: addr 8'hAB, cmd 8'hB0, size 0 -> words AB00, 00B0, AB00+00B0=ABB0, 0000; packet_end once; no pop_request.
- Data reply: addr AB, cmd A2, size 6, payload FFA1,0001,0002,AB45,FFA3,FFA1 -> AB00, 06A2, payload in order, checksum 5BCF, 0000; word_num counts 0..5.
- Back-pressure: push_done delayed by 0..7 random cycles -> push_data stable while request is high; same word sequence and checksum as the zero-wait case.
- Slow source: pop_done delayed 10 cycles per word -> push_request stays low during FETCH; output packet unchanged.
- start pulsed while busy -> ignored; exactly one packet is emitted.
- rst asserted during the third payload word -> all outputs return to reset values asynchronously; a subsequent start produces a full, correct packet.

Source files
------------

// File: rtl/service_packet_encoder_pkg.sv
// Service protocol constants and header packing shared by the reply framer.
// Command codes sit with the header layout so encoder and decoder agree on both.
package service_packet_encoder_pkg;

    localparam logic [7:0]  TCC_STATUS_REPLY = 8'hB0;
    localparam logic [7:0]  TCC_DATA_REPLY   = 8'hB2;
    localparam logic [7:0]  ADDR_PAD         = 8'h00;
    localparam logic [15:0] TRAILER_WORD     = 16'h0000;

    // Address sits in the upper byte; lower byte is padding.
    function automatic logic [15:0] addr_word(input logic [7:0] addr);
        return {addr, ADDR_PAD};
    endfunction

    function automatic logic [15:0] size_word(input logic [7:0] size, input logic [7:0] cmd);
        return {size, cmd};
    endfunction

    // Carry out of bit 15 is dropped.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/service_checksum_acc.sv
// Clearable 16-bit running checksum; clear has priority over add.
module service_checksum_acc
    import service_packet_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add_en,
    input  logic [15:0] add_word,
    output logic [15:0] sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         sum <= '0;
        else if (clr)    sum <= '0;
        else if (add_en) sum <= csum_add(sum, add_word);
    end

endmodule

// File: rtl/service_packet_encoder.sv
// Reply packet framer: header, payload pulled from a FIFO, checksum, trailer.
// Each word is offered with push_request and advanced on push_done.
module service_packet_encoder
    import service_packet_encoder_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int MAX_SIZE = 255
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        cmd,
    input  logic [7:0]        size,
    output logic              pop_request,
    input  logic              pop_done,
    input  logic [15:0]       pop_data,
    output logic              push_request,
    input  logic              push_done,
    output logic [15:0]       push_data,
    output logic              busy,
    output logic [7:0]        word_num,
    output logic              packet_end
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SIZE, S_FETCH, S_DATA, S_CSUM, S_TAIL} state_t;

    state_t            state, state_nxt;
    logic              push_req_nxt, pop_req_nxt, packet_end_nxt;
    logic [7:0]        word_num_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        cmd_q, size_q, size_clamped;
    logic [15:0]       data_q, csum;
    logic              csum_clr, csum_add_en, more_words;

    assign size_clamped = (32'(size) > MAX_SIZE) ? 8'(MAX_SIZE) : size;
    assign more_words   = ({1'b0, word_num} + 9'd1) < {1'b0, size_q};
    assign busy         = (state != S_IDLE);

    // Requests are registered: each word gets one idle cycle before its request rises.
    always_comb begin
        state_nxt      = state;
        push_req_nxt   = push_request;
        pop_req_nxt    = pop_request;
        packet_end_nxt = 1'b0;
        word_num_nxt   = word_num;
        csum_clr       = 1'b0;
        csum_add_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt    = S_ADDR;
                    push_req_nxt = 1'b1;
                    word_num_nxt = '0;
                    csum_clr     = 1'b1;
                end
            end
            S_FETCH: begin
                if (!pop_request) begin
                    pop_req_nxt = 1'b1;
                end else if (pop_done) begin
                    pop_req_nxt = 1'b0;
                    state_nxt   = S_DATA;
                end
            end
            default: begin
                if (!push_request) begin
                    push_req_nxt = 1'b1;
                end else if (push_done) begin
                    push_req_nxt = 1'b0;
                    csum_add_en  = (state == S_ADDR) || (state == S_SIZE) || (state == S_DATA);
                    if (state == S_ADDR) begin
                        state_nxt = S_SIZE;
                    end else if (state == S_SIZE) begin
                        state_nxt = (size_q != 8'd0) ? S_FETCH : S_CSUM;
                    end else if (state == S_DATA) begin
                        word_num_nxt = word_num + 8'd1;
                        state_nxt    = more_words ? S_FETCH : S_CSUM;
                    end else if (state == S_CSUM) begin
                        state_nxt = S_TAIL;
                    end else begin
                        state_nxt      = S_IDLE;
                        packet_end_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        push_data = '0;
        case (state)
            S_ADDR:  push_data = addr_word(addr_q);
            S_SIZE:  push_data = size_word(size_q, cmd_q);
            S_DATA:  push_data = data_q;
            S_CSUM:  push_data = csum;
            S_TAIL:  push_data = TRAILER_WORD;
            default: push_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            push_request <= 1'b0;
            pop_request  <= 1'b0;
            packet_end   <= 1'b0;
            word_num     <= '0;
            addr_q       <= '0;
            cmd_q        <= '0;
            size_q       <= '0;
            data_q       <= '0;
        end else begin
            state        <= state_nxt;
            push_request <= push_req_nxt;
            pop_request  <= pop_req_nxt;
            packet_end   <= packet_end_nxt;
            word_num     <= word_num_nxt;
            if (state == S_IDLE && start) begin
                addr_q <= addr;
                cmd_q  <= cmd;
                size_q <= size_clamped;
            end
            if (state == S_FETCH && pop_request && pop_done)
                data_q <= pop_data;
        end
    end

    service_checksum_acc u_csum (
        .clk      (clk),
        .rst      (rst),
        .clr      (csum_clr),
        .add_en   (csum_add_en),
        .add_word (push_data),
        .sum      (csum)
    );

endmodule

// File: tb/tb_service_packet_encoder.sv
// Directed and randomized packets against a word-list model of the reply format.
module tb_service_packet_encoder;

    localparam int MAX_SIZE = 255;

    logic        clk = 1'b0;
    logic        rst, start, pop_done, push_done;
    logic [7:0]  addr, cmd, size;
    logic [15:0] pop_data;
    logic        pop_request, push_request, busy, packet_end;
    logic [15:0] push_data;
    logic [7:0]  word_num;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] pay_q[$];
    logic [15:0] exp_q[$];

    service_packet_encoder #(.ADDR_W(8), .MAX_SIZE(MAX_SIZE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .addr         (addr),
        .cmd          (cmd),
        .size         (size),
        .pop_request  (pop_request),
        .pop_done     (pop_done),
        .pop_data     (pop_data),
        .push_request (push_request),
        .push_done    (push_done),
        .push_data    (push_data),
        .busy         (busy),
        .word_num     (word_num),
        .packet_end   (packet_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected word list built straight from the packet format rules.
    function automatic void build_expected(input int a, input int c, input int s);
        int n, sum;
        n = (s > MAX_SIZE) ? MAX_SIZE : s;
        exp_q.delete();
        exp_q.push_back(16'(a * 256));
        exp_q.push_back(16'(n * 256 + c));
        sum = a * 256 + n * 256 + c;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pay_q[i]);
            sum = sum + int'(pay_q[i]);
        end
        exp_q.push_back(16'(sum % 65536));
        exp_q.push_back(16'h0000);
    endfunction

    task automatic fill_payload(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(16'($urandom));
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_busy"},      busy, 0);
        check({where, "_push_req"},  push_request, 0);
        check({where, "_pop_req"},   pop_request, 0);
        check({where, "_push_data"}, push_data, 0);
        check({where, "_word_num"},  word_num, 0);
        check({where, "_pkt_end"},   packet_end, 0);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic run_packet(input int a, input int c, input int s, input int push_wait_max,
                              input int pop_wait, input bit noisy, input int abort_word,
                              input bit check_min);
        int idx = 0, pidx = 0, cyc, push_cnt = 0, pop_cnt = 0, nwords, npay;
        bit push_active = 0, pop_active = 0, done = 0, prev_push = 0, prev_pop = 0;
        logic [15:0] held = '0;
        build_expected(a, c, s);
        nwords = exp_q.size();
        npay   = nwords - 4;
        start = 1'b1; addr = 8'(a); cmd = 8'(c); size = 8'(s);
        @(negedge clk);
        start = 1'b0; addr = 8'($urandom); cmd = 8'($urandom); size = 8'($urandom);
        check("first_req", push_request, 1);
        check("busy_rise", busy, 1);
        cyc = 1;
        while (cyc < 20000) begin
            push_done = 1'b0; pop_done = 1'b0; start = 1'b0;
            if (packet_end) begin
                done = 1;
                break;
            end
            if (prev_push) check("push_req_drop", push_request, 0);
            if (prev_pop)  check("pop_req_drop", pop_request, 0);
            prev_push = 0; prev_pop = 0;
            if (push_request) begin
                if (!push_active) begin
                    push_active = 1;
                    held = push_data;
                    push_cnt = $urandom_range(push_wait_max, 0);
                end else begin
                    check("push_stable", push_data, held);
                end
                if (push_cnt == 0) begin
                    if (idx < nwords) check($sformatf("word%0d", idx), push_data, exp_q[idx]);
                    else              check("extra_word", idx, nwords);
                    if (idx >= 2 && idx < nwords - 2) check("word_num", word_num, idx - 2);
                    if (abort_word >= 0 && idx == abort_word) begin
                        #2 rst = 1'b1;
                        #1 check_reset_outputs("abort");
                        @(negedge clk);
                        check_reset_outputs("abort_hold");
                        rst = 1'b0;
                        return;
                    end
                    if (noisy && (idx == 1 || idx == nwords - 1)) begin
                        start = 1'b1; addr = 8'($urandom); cmd = 8'($urandom); size = 8'($urandom);
                    end
                    idx++;
                    push_done = 1'b1; push_active = 0; prev_push = 1;
                end else begin
                    push_cnt--;
                end
            end else if (noisy && !pop_request) begin
                push_done = 1'b1;
            end
            if (pop_request) begin
                check("push_in_fetch", push_request, 0);
                if (!pop_active) begin
                    pop_active = 1;
                    pop_cnt = pop_wait;
                end
                if (pop_cnt == 0) begin
                    pop_data = (pidx < npay) ? pay_q[pidx] : 16'hDEAD;
                    pidx++;
                    pop_done = 1'b1; pop_active = 0; prev_pop = 1;
                end else begin
                    pop_cnt--;
                    pop_data = 16'($urandom);
                end
            end else if (noisy && !push_request) begin
                pop_data = 16'($urandom);
                pop_done = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        push_done = 1'b0; pop_done = 1'b0; start = 1'b0;
        check("packet_end_seen", done, 1);
        check("word_count", idx, nwords);
        check("pop_count", pidx, npay);
        check("busy_fall", busy, 0);
        if (check_min) check("duration", cyc, 8 + 4 * npay);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("after_pkt_end", packet_end, 0);
            check("after_busy", busy, 0);
            check("after_push_req", push_request, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pop_done = 1'b0; push_done = 1'b0;
        addr = '0; cmd = '0; size = '0; pop_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Status reply, no payload
        pay_q.delete();
        run_packet(8'hAB, 8'hB0, 0, 0, 0, 0, -1, 1);

        // Data reply with fixed payload (checksum 5BCF)
        pay_q = '{16'hFFA1, 16'h0001, 16'h0002, 16'hAB45, 16'hFFA3, 16'hFFA1};
        run_packet(8'hAB, 8'hA2, 6, 0, 0, 0, -1, 1);

        // Back-pressure on the sink
        fill_payload(6);
        run_packet(8'hAB, 8'hA2, 6, 7, 0, 0, -1, 0);
        fill_payload(9);
        run_packet($urandom_range(255, 0), $urandom_range(255, 0), 9, 7, 0, 0, -1, 0);

        // Slow payload source
        fill_payload(5);
        run_packet(8'h3C, 8'hB2, 5, 0, 10, 0, -1, 0);

        // Start and stray handshakes while busy
        fill_payload(4);
        run_packet(8'h5A, 8'hB2, 4, 3, 2, 1, -1, 0);

        // Reset during third payload word, then a full packet
        fill_payload(6);
        run_packet(8'h77, 8'hB2, 6, 2, 1, 0, 4, 0);
        @(negedge clk);
        fill_payload(6);
        run_packet(8'h77, 8'hB2, 6, 2, 1, 0, -1, 0);

        // Random packets and the largest size
        for (int r = 0; r < 4; r++) begin
            int sz;
            sz = $urandom_range(12, 0);
            fill_payload(sz);
            run_packet($urandom_range(255, 0), $urandom_range(255, 0), sz,
                       $urandom_range(3, 0), $urandom_range(3, 0), 0, -1, 0);
        end
        fill_payload(255);
        run_packet(8'hFF, 8'hB2, 255, 0, 0, 0, -1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
